// File: rtl/transition_test_ctrl.sv
// Two-pattern transition (delay-fault) test sequencer for a single 2-input cell.
// Holds V1 to settle, launches V2, then samples the cell output and keeps a fail tally.
module transition_test_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned CAPTURE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] v1,
    input  logic [1:0] v2,
    input  logic       exp_init,
    input  logic       exp_final,
    input  logic       clr_cnt,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_count
);

    typedef enum logic [1:0] {IDLE, INIT, LAUNCH, DONE} state_t;

    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] CAPTURE_LD = 4'(CAPTURE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] drv, drv_nxt;
    logic [1:0] v1_q, v1_nxt;
    logic [1:0] v2_q, v2_nxt;
    logic       ei_q, ei_nxt;
    logic       ef_q, ef_nxt;
    logic       init_ok, init_ok_nxt;
    logic       pass_nxt;
    logic [7:0] fc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            drv        <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            ei_q       <= 1'b0;
            ef_q       <= 1'b0;
            init_ok    <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            drv        <= drv_nxt;
            v1_q       <= v1_nxt;
            v2_q       <= v2_nxt;
            ei_q       <= ei_nxt;
            ef_q       <= ef_nxt;
            init_ok    <= init_ok_nxt;
            pass       <= pass_nxt;
            fail_count <= fc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        drv_nxt     = drv;
        v1_nxt      = v1_q;
        v2_nxt      = v2_q;
        ei_nxt      = ei_q;
        ef_nxt      = ef_q;
        init_ok_nxt = init_ok;
        pass_nxt    = pass;
        fc_nxt      = fail_count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    v1_nxt    = v1;
                    v2_nxt    = v2;
                    ei_nxt    = exp_init;
                    ef_nxt    = exp_final;
                    drv_nxt   = v1;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = INIT;
                end
            end
            INIT: begin
                if (cnt == 4'd0) begin
                    init_ok_nxt = (dut_y == ei_q);
                    drv_nxt     = v2_q;
                    cnt_nxt     = CAPTURE_LD;
                    state_nxt   = LAUNCH;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            LAUNCH: begin
                if (cnt == 4'd0) begin
                    pass_nxt  = init_ok & (dut_y == ef_q);
                    state_nxt = DONE;
                    if (!pass_nxt && fail_count != 8'hff)
                        fc_nxt = fail_count + 8'd1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                drv_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A clear coinciding with a failing result still leaves zero.
        if (clr_cnt)
            fc_nxt = '0;
    end

    assign dut_a = drv[1];
    assign dut_b = drv[0];
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

endmodule
